// File: rtl/deser_align_ctrl.sv
// deser_align_ctrl
// Word-alignment and framing controller for the 10-bit receive deserializer.
// Serial bits are shifted into a 10-bit window, and the controller hunts for a
// K28.5 comma of either disparity to fix the word boundary. Once aligned, it
// emits one word per 10 valid bits. A HUNT/SYNC/LOCKED state machine tracks
// alignment and detects loss of lock.
// All outputs are registered, and the reset is synchronous and active-low.

module deser_align_ctrl #(
  parameter logic [9:0]  COMMA_P  = 10'h0FA,
  parameter logic [9:0]  COMMA_N  = 10'h305,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned LOSS_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       ser_in,
  input  logic       bit_valid,
  output logic [9:0] word_out,
  output logic       word_valid,
  output logic       word_is_comma,
  output logic       locked,
  output logic       realign
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] LOSS_TGT = CNT_W'(LOSS_CNT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Returns 1 when the window holds either disparity of K28.5.
  function automatic logic is_comma(input logic [9:0] w);
    return (w == COMMA_P) || (w == COMMA_N);
  endfunction

  // Increments a counter but holds it at all-ones, so it never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1'b1);
    end
  endfunction

  state_t           state_q, state_d;
  logic [9:0]       window_q, window_d;
  logic [3:0]       phase_q, phase_d;
  logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [9:0]       word_out_q, word_out_d;
  logic             word_valid_q, word_valid_d;
  logic             word_is_comma_q, word_is_comma_d;
  logic             locked_q, locked_d;
  logic             realign_q, realign_d;

  logic [9:0]       nxt_s;
  logic             bit_take_s;
  logic             comma_hit_s;
  logic             boundary_s;
  logic [3:0]       phase_inc_s;
  logic [CNT_W-1:0] good_inc_s;
  logic [CNT_W-1:0] err_inc_s;

  // Candidate window, qualified comma/boundary events and counter increments.
  always_comb begin
    nxt_s       = {window_q[8:0], ser_in};
    bit_take_s  = bit_valid & enable;
    comma_hit_s = bit_take_s & is_comma(nxt_s);
    boundary_s  = bit_take_s & (phase_q == 4'd9);
    good_inc_s  = sat_inc(good_cnt_q);
    err_inc_s   = sat_inc(err_cnt_q);
    if (phase_q == 4'd9) begin
      phase_inc_s = 4'd0;
    end else begin
      phase_inc_s = phase_q + 4'd1;
    end
  end

  // Next-state logic, counters and output strobes for the alignment state machine.
  always_comb begin
    state_d         = state_q;
    window_d        = window_q;
    phase_d         = phase_q;
    good_cnt_d      = good_cnt_q;
    err_cnt_d       = err_cnt_q;
    word_out_d      = word_out_q;
    word_valid_d    = 1'b0;
    word_is_comma_d = 1'b0;
    realign_d       = 1'b0;

    if (!enable) begin
      // Disable overrides every event: drop back to HUNT with counters cleared.
      state_d    = ST_HUNT;
      phase_d    = 4'd0;
      good_cnt_d = '0;
      err_cnt_d  = '0;
      realign_d  = (state_q != ST_HUNT);
    end else begin
      if (bit_take_s) begin
        window_d = nxt_s;
        phase_d  = phase_inc_s;
      end else begin
        window_d = window_q;
      end

      case (state_q)
        ST_HUNT: begin
          if (comma_hit_s) begin
            // The acquiring comma fixes the boundary and is emitted as a word.
            word_out_d      = nxt_s;
            word_valid_d    = 1'b1;
            word_is_comma_d = 1'b1;
            phase_d         = 4'd0;
            good_cnt_d      = CNT_W'(1'b1);
            err_cnt_d       = '0;
            state_d         = (LOCK_CNT <= 32'd1) ? ST_LOCKED : ST_SYNC;
          end else begin
            state_d = ST_HUNT;
          end
        end

        ST_SYNC: begin
          if (boundary_s) begin
            word_out_d      = nxt_s;
            word_valid_d    = 1'b1;
            word_is_comma_d = comma_hit_s;
            if (comma_hit_s) begin
              good_cnt_d = good_inc_s;
              if (good_inc_s >= LOCK_TGT) begin
                state_d   = ST_LOCKED;
                err_cnt_d = '0;
              end else begin
                state_d = ST_SYNC;
              end
            end else begin
              good_cnt_d = good_cnt_q;
            end
          end else if (comma_hit_s) begin
            // Comma in the wrong place: give up; the hunt resumes on the next bit.
            state_d    = ST_HUNT;
            realign_d  = 1'b1;
            good_cnt_d = '0;
          end else begin
            state_d = ST_SYNC;
          end
        end

        ST_LOCKED: begin
          if (boundary_s) begin
            word_out_d      = nxt_s;
            word_valid_d    = 1'b1;
            word_is_comma_d = comma_hit_s;
            if (comma_hit_s) begin
              err_cnt_d = '0;
            end else begin
              err_cnt_d = err_cnt_q;
            end
          end else if (comma_hit_s) begin
            err_cnt_d = err_inc_s;
            if (err_inc_s >= LOSS_TGT) begin
              state_d    = ST_HUNT;
              realign_d  = 1'b1;
              err_cnt_d  = '0;
              good_cnt_d = '0;
            end else begin
              state_d = ST_LOCKED;
            end
          end else begin
            state_d = ST_LOCKED;
          end
        end

        default: begin
          state_d    = ST_HUNT;
          phase_d    = 4'd0;
          good_cnt_d = '0;
          err_cnt_d  = '0;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_HUNT;
      window_q        <= '0;
      phase_q         <= 4'd0;
      good_cnt_q      <= '0;
      err_cnt_q       <= '0;
      word_out_q      <= '0;
      word_valid_q    <= 1'b0;
      word_is_comma_q <= 1'b0;
      locked_q        <= 1'b0;
      realign_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      window_q        <= window_d;
      phase_q         <= phase_d;
      good_cnt_q      <= good_cnt_d;
      err_cnt_q       <= err_cnt_d;
      word_out_q      <= word_out_d;
      word_valid_q    <= word_valid_d;
      word_is_comma_q <= word_is_comma_d;
      locked_q        <= locked_d;
      realign_q       <= realign_d;
    end
  end

  assign word_out      = word_out_q;
  assign word_valid    = word_valid_q;
  assign word_is_comma = word_is_comma_q;
  assign locked        = locked_q;
  assign realign       = realign_q;

endmodule

// File: tb/tb_deser_align_ctrl.sv
// Testbench for deser_align_ctrl. It checks the outputs every cycle against a
// bit-stream reference model, then runs a vector table for the acquisition
// case, directed sequences for the multi-cycle corner cases, and random
// segment traffic.

module tb_deser_align_ctrl;

  localparam logic [9:0]  COMMA_P  = 10'h0FA;
  localparam logic [9:0]  COMMA_N  = 10'h305;
  localparam int unsigned LOCK_CNT = 3;
  localparam int unsigned LOSS_CNT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       ser_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic [9:0] word_out;
  logic       word_valid, word_is_comma, locked, realign;

  deser_align_ctrl #(
    .COMMA_P (COMMA_P),
    .COMMA_N (COMMA_N),
    .LOCK_CNT(LOCK_CNT),
    .LOSS_CNT(LOSS_CNT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .ser_in       (ser_in),
    .bit_valid    (bit_valid),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .word_is_comma(word_is_comma),
    .locked       (locked),
    .realign      (realign)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int nstrobe = 0;
  int gapc    = 0;
  logic [9:0] words_q[$];

  // Reference model: the alignment is tracked as the number of valid bits
  // since the last anchor point. A boundary is every tenth bit after it.
  localparam int M_HUNT = 0, M_SYNC = 1, M_LOCK = 2;
  int         m_state = M_HUNT;
  int         m_win = 0, m_since = 0, m_good = 0, m_err = 0;
  logic [9:0] e_word = 10'd0;
  bit         e_wv = 1'b0, e_comma = 1'b0, e_locked = 1'b0, e_realign = 1'b0;

  task automatic model_step(input bit r, input bit en, input bit bv, input bit b);
    int w;
    bit hit, bnd;
    if (!r) begin
      m_state = M_HUNT; m_win = 0; m_since = 0; m_good = 0; m_err = 0;
      e_word = 10'd0; e_wv = 1'b0; e_comma = 1'b0; e_realign = 1'b0;
    end else if (!en) begin
      e_realign = (m_state != M_HUNT);
      m_state = M_HUNT; m_since = 0; m_good = 0; m_err = 0;
      e_wv = 1'b0; e_comma = 1'b0;
    end else begin
      e_wv = 1'b0; e_comma = 1'b0; e_realign = 1'b0;
      if (bv) begin
        w   = ((m_win << 1) | int'(b)) & 32'h3FF;
        hit = (w == int'(COMMA_P)) || (w == int'(COMMA_N));
        bnd = ((m_since + 1) % 10) == 0;
        m_since++;
        m_win = w;
        case (m_state)
          M_HUNT: if (hit) begin
            e_wv = 1'b1; e_comma = 1'b1; e_word = w[9:0];
            m_since = 0; m_good = 1; m_err = 0;
            m_state = (LOCK_CNT == 1) ? M_LOCK : M_SYNC;
          end
          M_SYNC: if (bnd) begin
            e_wv = 1'b1; e_comma = hit; e_word = w[9:0];
            if (hit) begin
              m_good++;
              if (m_good >= int'(LOCK_CNT)) begin m_state = M_LOCK; m_err = 0; end
            end
          end else if (hit) begin
            m_state = M_HUNT; e_realign = 1'b1; m_good = 0;
          end
          M_LOCK: if (bnd) begin
            e_wv = 1'b1; e_comma = hit; e_word = w[9:0];
            if (hit) m_err = 0;
          end else if (hit) begin
            m_err++;
            if (m_err >= int'(LOSS_CNT)) begin
              m_state = M_HUNT; e_realign = 1'b1; m_err = 0; m_good = 0;
            end
          end
          default: m_state = M_HUNT;
        endcase
      end
    end
    e_locked = (m_state == M_LOCK);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance the model, compare all outputs one step after the edge.
  task automatic drive(input bit r, input bit en, input bit bv, input bit b);
    logic [13:0] act, exp;
    rst_n = r; enable = en; bit_valid = bv; ser_in = b;
    @(posedge clk);
    model_step(r, en, bv, b);
    #1;
    act = {word_valid, word_is_comma, locked, realign, word_out};
    exp = {e_wv, e_comma, e_locked, e_realign, e_word};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cycle_model: got {wv,comma,lock,realign,word}=%b expected %b at %0t", act, exp, $time);
    end
    if (word_valid === 1'b1) begin
      nstrobe++;
      words_q.push_back(word_out);
    end
  endtask

  // gap: 0 none, 1 an invalid bit every third cycle, 2 random invalid bits
  task automatic send_word(input logic [9:0] w, input int gap);
    for (int i = 9; i >= 0; i--) begin
      if (gap == 1) begin
        gapc++;
        if (gapc % 3 == 0) drive(1'b1, 1'b1, 1'b0, 1'($urandom));
      end else if (gap == 2) begin
        if ($urandom_range(0, 4) == 0) drive(1'b1, 1'b1, 1'b0, 1'($urandom));
      end
      drive(1'b1, 1'b1, 1'b1, w[i]);
    end
  endtask

  typedef struct {
    bit         r, en, bv, b;
    bit         wv, comma, lk, ra;
    logic [9:0] word;
  } vec_t;

  vec_t       tbl[15];
  logic [9:0] cm;
  logic [9:0] exp_words[5];
  logic [9:0] d155;

  initial begin
    // Table: reset, three random-looking bits, then the RD- comma MSB first.
    cm = COMMA_P;
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000};
    for (int i = 0; i < 10; i++) begin
      tbl[4 + i] = '{1'b1, 1'b1, 1'b1, cm[9 - i], (i == 9), (i == 9), 1'b0, 1'b0,
                     (i == 9) ? COMMA_P : 10'h000};
    end
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, COMMA_P};

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].r, tbl[i].en, tbl[i].bv, tbl[i].b);
      chk($sformatf("t1_vec%0d", i),
          int'({word_valid, word_is_comma, locked, realign, word_out}),
          int'({tbl[i].wv, tbl[i].comma, tbl[i].lk, tbl[i].ra, tbl[i].word}));
    end

    // Two more aligned commas with data between: LOCKED after the third.
    d155 = 10'h155;
    nstrobe = 0;
    send_word(d155, 0);
    send_word(COMMA_P, 0);
    chk("t2_not_yet_locked", int'(locked), 0);
    send_word(d155, 0);
    send_word(COMMA_P, 0);
    chk("t2_locked", int'(locked), 1);
    chk("t2_comma_strobe", int'({word_valid, word_is_comma}), 3);
    chk("t2_strobes", nstrobe, 4);

    // Four commas, each one bit further from the boundary: loss of lock.
    for (int k = 0; k < 4; k++) begin
      if (k == 3) chk("t3_still_locked", int'(locked), 1);
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      send_word(COMMA_P, 0);
    end
    chk("t3_realign", int'(realign), 1);
    chk("t3_unlocked", int'(locked), 0);
    nstrobe = 0;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t3_realign_1cyc", int'(realign), 0);
    send_word(d155, 0);
    send_word(d155, 0);
    chk("t3_no_strobe_in_hunt", nstrobe, 0);

    // Stream with an invalid bit every third cycle: the words are unchanged.
    words_q.delete();
    gapc = 0;
    exp_words[0] = COMMA_P; exp_words[1] = 10'h155; exp_words[2] = 10'h2AA;
    exp_words[3] = COMMA_P; exp_words[4] = 10'h155;
    for (int i = 0; i < 5; i++) send_word(exp_words[i], 1);
    chk("t4_word_count", words_q.size(), 5);
    for (int i = 0; i < 5 && i < words_q.size(); i++)
      chk($sformatf("t4_word%0d", i), int'(words_q[i]), int'(exp_words[i]));

    // Lock up, disable mid-word, then re-acquire on the RD+ comma.
    send_word(10'h2AA, 0);
    send_word(COMMA_P, 0);
    chk("t5_locked", int'(locked), 1);
    for (int i = 9; i >= 5; i--) drive(1'b1, 1'b1, 1'b1, d155[i]);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    chk("t5_disable_out", int'({word_valid, locked, realign}), 1);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5_realign_once", int'(realign), 0);
    send_word(COMMA_N, 0);
    chk("t5_reacquire", int'({word_valid, word_is_comma, locked, word_out}),
        int'({1'b1, 1'b1, 1'b0, COMMA_N}));

    // Reset in the middle of a word in SYNC.
    for (int i = 9; i >= 6; i--) drive(1'b1, 1'b1, 1'b1, d155[i]);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    chk("t6_reset_out", int'({word_valid, word_is_comma, locked, realign, word_out}), 0);
    nstrobe = 0;
    send_word(d155, 0);
    chk("t6_no_stale", nstrobe, 0);

    // Random segments: commas, data, slips, gaps, disables and resets.
    for (int s = 0; s < 300; s++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        drive(1'b0, 1'b1, 1'($urandom), 1'($urandom));
      end else if (r < 8) begin
        repeat ($urandom_range(1, 3)) drive(1'b1, 1'b0, 1'($urandom), 1'($urandom));
      end else if (r < 50) begin
        send_word(($urandom_range(0, 1) == 1) ? COMMA_P : COMMA_N, 2);
      end else if (r < 65) begin
        repeat ($urandom_range(1, 3)) drive(1'b1, 1'b1, 1'b1, 1'($urandom));
      end else begin
        send_word(10'($urandom), 2);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
